// File: rtl/aes128_iter_ctrl.sv
// ----------------------------------------------------------------------------
// aes128_iter_ctrl
// Iterative AES-128 encryption controller. One shared round datapath plus an
// on-the-fly key schedule runs the ten AES rounds, one round per clock.
// A plaintext/key pair is accepted with a valid/ready handshake. The
// ciphertext is returned with a valid/ready handshake. Only one block is in
// flight at a time.
// ----------------------------------------------------------------------------
module aes128_iter_ctrl #(
  parameter int          NR        = 10,     // AES-128 round count; only 10 is legal
  parameter logic [7:0]  RCON_INIT = 8'h01   // Rcon used for the round-1 key
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  plaintext,
  input  logic [127:0]  key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  ciphertext,
  output logic          busy,
  output logic [3:0]    round_idx
);

  // The last full round (with MixColumns) before the final round.
  localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  // AES S-box. Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t         r_state;
  state_t         w_next;
  logic [127:0]   r_st;
  logic [127:0]   r_rk;
  logic [7:0]     r_rcon;
  logic [3:0]     r_round_idx;
  logic [127:0]   r_ct;

  // --------------------------------------------------------------------------
  // AES primitives
  // --------------------------------------------------------------------------
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    // Entry b lives at bit offset (255-b)*8; ~b equals 255-b for 8 bits.
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  // Multiply by x in GF(2^8), reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One key-expansion step: derives the next 128-bit round key from the
  // current round key and the Rcon value that belongs to the new key.
  function automatic logic [127:0] key_step(input logic [127:0] w,
                                            input logic [7:0]   rc);
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    t  = sub_word({w[23:0], w[31:24]}) ^ {rc, 24'h000000};
    w0 = w[127:96] ^ t;
    w1 = w[95:64]  ^ w0;
    w2 = w[63:32]  ^ w1;
    w3 = w[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes followed by ShiftRows. Byte i holds row i%4 and column i/4.
  // It is stored at bits [127-8i -: 8].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(row + 4*c) -: 8] = sbox(s[127 - 8*(row + 4*((c + row) % 4)) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    end
    return r;
  endfunction

  // Full middle round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  function automatic logic [127:0] encrypt_round(input logic [127:0] s,
                                                 input logic [127:0] rk);
    return mix_columns(sub_shift(s)) ^ rk;
  endfunction

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  //       pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake/status outputs.
  // NOTE: every output of this block gets a default first, so no path
  //       leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (r_round_idx == LAST_ROUND) w_next = S_FINAL;
      end
      S_FINAL: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Round datapath and key schedule
  // --------------------------------------------------------------------------

  // Round state, round key, Rcon, round counter and ciphertext register.
  // NOTE: all of these are reset, so an aborted block leaves no residue that
  //       could leak into the next ciphertext or the visible outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st        <= '0;
      r_rk        <= '0;
      r_rcon      <= '0;
      r_round_idx <= '0;
      r_ct        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Inputs are sampled only on the accept edge. Round 0 is AddRoundKey.
          if (in_valid) begin
            r_st        <= plaintext ^ key;
            r_rk        <= key_step(key, RCON_INIT);
            r_rcon      <= xtime(RCON_INIT);
            r_round_idx <= 4'd1;
          end
        end
        S_ROUND: begin
          r_st        <= encrypt_round(r_st, r_rk);
          r_rk        <= key_step(r_rk, r_rcon);
          r_rcon      <= xtime(r_rcon);
          r_round_idx <= r_round_idx + 4'd1;
        end
        S_FINAL: begin
          // The last round has no MixColumns.
          r_ct        <= sub_shift(r_st) ^ r_rk;
          r_round_idx <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign ciphertext = r_ct;
  assign round_idx  = r_round_idx;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes128_iter_ctrl
// Directed testbench for aes128_iter_ctrl. It applies the FIPS-197 known-answer
// vectors and exercises backpressure, back-to-back blocks, reset in the middle
// of a block, and the key schedule at the Rcon wrap.
// ----------------------------------------------------------------------------
module tb_aes128_iter_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam int           LAT    = 10;   // edges from accept to out_valid
  localparam int           WAIT_MAX = 40;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;

  aes128_iter_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output handshakes as the DUT sees them at the rising edge.
  always @(posedge clk) begin
    if (out_valid && out_ready) n_hs++;
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until out_valid rises. Return the number of edges taken, up to a
  // fixed limit.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < WAIT_MAX) begin
      step();
      n++;
    end
  endtask

  // Offer a pair and keep it offered for exactly one edge.
  task automatic accept_one(input logic [127:0] pt, input logic [127:0] k);
    plaintext = pt;
    key       = k;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    int  n;
    int  hs0;
    bit  seen;
    bit  p9;
    bit  p10;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;

    // ---------------- reset state ----------------
    #12;
    check("rst in_ready",   in_ready,   1);
    check("rst out_valid",  out_valid,  0);
    check("rst busy",       busy,       0);
    check("rst round_idx",  round_idx,  0);
    check("rst ciphertext", ciphertext, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // ---------------- FIPS-197 C.1, out_ready held high early ----------------
    out_ready = 1'b1;
    accept_one(C1_PT, C1_KEY);
    plaintext = '1;
    key       = '1;
    check("c1 busy after accept",  busy,      1);
    check("c1 in_ready after acc", in_ready,  0);
    check("c1 round_idx 1",        round_idx, 1);
    wait_out(n);
    check("c1 latency",    n,          LAT);
    check("c1 ciphertext", ciphertext, C1_CT);
    check("c1 done busy",  busy,       0);
    check("c1 done idx",   round_idx,  0);
    step();
    check("c1 pulse one cycle", out_valid, 0);
    check("c1 back idle",       in_ready,  1);

    // ---------------- App.B with backpressure and key probe ----------------
    out_ready = 1'b0;
    accept_one(B_PT, B_KEY);
    n   = 0;
    p9  = 1'b0;
    p10 = 1'b0;
    while (!out_valid && n < WAIT_MAX) begin
      if (round_idx == 4'd9) begin
        check("rk round 9", dut.r_rk, B_RK9);
        p9 = 1'b1;
      end
      if (round_idx == 4'd10) begin
        check("rk round 10", dut.r_rk, B_RK10);
        check("final busy",  busy,     1);
        p10 = 1'b1;
      end
      step();
      n++;
    end
    check("b probed round 9",  p9,  1);
    check("b probed round 10", p10, 1);
    check("b latency",    n,          LAT);
    check("b ciphertext", ciphertext, B_CT);
    plaintext = C1_PT;
    key       = C1_KEY;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp out_valid held", out_valid,  1);
      check("bp ct stable",      ciphertext, B_CT);
      check("bp in_ready low",   in_ready,   0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp handshake drop", out_valid, 0);
    check("bp idle",           in_ready,  1);
    step();
    check("bp no stray accept", busy, 0);

    // ---------------- back-to-back C.1 then App.B ----------------
    hs0       = n_hs;
    plaintext = C1_PT;
    key       = C1_KEY;
    in_valid  = 1'b1;
    step();
    plaintext = B_PT;
    key       = B_KEY;
    check("b2b first accepted", round_idx, 1);
    wait_out(n);
    check("b2b first latency", n,          LAT);
    check("b2b first ct",      ciphertext, C1_CT);
    step();
    check("b2b hs drop",       out_valid, 0);
    check("b2b idle gap",      in_ready,  1);
    step();
    check("b2b second accept", busy,      1);
    check("b2b second idx",    round_idx, 1);
    in_valid = 1'b0;
    wait_out(n);
    check("b2b second latency", n,          LAT);
    check("b2b second ct",      ciphertext, B_CT);
    step();
    check("b2b second drop", out_valid, 0);
    check("b2b output count", n_hs - hs0, 2);

    // ---------------- reset at round 5 of C.1 ----------------
    accept_one(C1_PT, C1_KEY);
    n = 0;
    while (round_idx != 4'd5 && n < WAIT_MAX) begin
      step();
      n++;
    end
    check("mid reach round 5", round_idx, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst in_ready",   in_ready,   1);
    check("mid rst out_valid",  out_valid,  0);
    check("mid rst busy",       busy,       0);
    check("mid rst round_idx",  round_idx,  0);
    check("mid rst ciphertext", ciphertext, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("mid no out_valid", seen,     0);
    check("mid idle",         in_ready, 1);
    accept_one(B_PT, B_KEY);
    wait_out(n);
    check("post rst latency", n,          LAT);
    check("post rst ct",      ciphertext, B_CT);
    step();
    check("post rst drop", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
